// File: rtl/nes_video_pkg.sv
// Shared types and default raster geometry for the NES video path.
// Pixels are 6-bit palette indices; the visible raster is 256x240.
package nes_video_pkg;

  localparam int NES_LINE_PIXELS = 256;
  localparam int NES_FRAME_LINES = 240;

  typedef logic [5:0] pix_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    LINE_WAIT = 2'd2
  } wctl_state_t;

endpackage

// File: rtl/raster_counter.sv
// Column/line counter for one frame. Column wraps at the line end and the
// line advances; the line wraps after the last line. clr and reset zero both.
module raster_counter
  import nes_video_pkg::*;
#(
  parameter int LINE_PIXELS = NES_LINE_PIXELS,
  parameter int FRAME_LINES = NES_FRAME_LINES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       last_pix,
  output logic       last_line
);

  logic [7:0] r_x;
  logic [7:0] r_y;

  assign last_pix  = (r_x == 8'(LINE_PIXELS - 1));
  assign last_line = (r_y == 8'(FRAME_LINES - 1));
  assign x         = r_x;
  assign y         = r_y;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      r_x <= 8'd0;
      r_y <= 8'd0;
    end else if (inc) begin
      if (last_pix) begin
        r_x <= 8'd0;
        r_y <= last_line ? 8'd0 : r_y + 8'd1;
      end else begin
        r_x <= r_x + 8'd1;
      end
    end
  end

endmodule

// File: rtl/pixel_fifo_ctrl.sv
// Gates PPU pixel strobes into the pixel FIFO write port, sequencing lines and
// frames; the PPU cannot stall, so pixels seen while the FIFO is full are dropped.
module pixel_fifo_ctrl
  import nes_video_pkg::*;
#(
  parameter int DATA_W      = 6,
  parameter int LINE_PIXELS = NES_LINE_PIXELS,
  parameter int FRAME_LINES = NES_FRAME_LINES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              line_go,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              fifo_full,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_data_in,
  output logic [7:0]        x,
  output logic [7:0]        y,
  output logic              busy,
  output logic              line_done,
  output logic              frame_done,
  output logic [7:0]        drop_cnt,
  output logic              seq_err
);

  wctl_state_t r_state;
  logic [7:0]  r_drop_cnt;
  logic        r_seq_err;
  logic        r_line_done;
  logic        r_frame_done;

  logic w_take;
  logic w_last_pix;
  logic w_last_line;

  // A strobe consumes a pixel slot only when active and not overridden by a resync.
  assign w_take       = (r_state == ACTIVE) && pix_valid && !frame_start;
  assign fifo_we      = w_take && !fifo_full;
  assign fifo_data_in = pix_data;
  assign busy         = (r_state != IDLE);
  assign drop_cnt     = r_drop_cnt;
  assign seq_err      = r_seq_err;
  assign line_done    = r_line_done;
  assign frame_done   = r_frame_done;

  raster_counter #(
    .LINE_PIXELS(LINE_PIXELS),
    .FRAME_LINES(FRAME_LINES)
  ) u_raster (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (w_take),
    .clr      (frame_start),
    .x        (x),
    .y        (y),
    .last_pix (w_last_pix),
    .last_line(w_last_line)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_drop_cnt   <= 8'd0;
      r_seq_err    <= 1'b0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
      if (frame_start) begin
        r_state    <= ACTIVE;
        r_drop_cnt <= 8'd0;
        if (r_state != IDLE) r_seq_err <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (pix_valid) r_seq_err <= 1'b1;
          end
          ACTIVE: begin
            if (pix_valid) begin
              if (fifo_full && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
              if (w_last_pix) begin
                r_line_done <= 1'b1;
                if (w_last_line) begin
                  r_frame_done <= 1'b1;
                  r_state      <= IDLE;
                end else begin
                  r_state <= LINE_WAIT;
                end
              end
            end
          end
          LINE_WAIT: begin
            if (pix_valid) r_seq_err <= 1'b1;
            if (line_go) r_state <= ACTIVE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_fifo_ctrl.sv
// Directed and randomized checks of pixel_fifo_ctrl on a 4x3 raster against a
// position-based reference model, plus a full 256x240 frame on a default instance.
module tb_pixel_fifo_ctrl;

  localparam int LP = 4;
  localparam int FL = 3;

  logic       clk;
  logic       reset_n, frame_start, line_go, pix_valid, fifo_full;
  logic [5:0] pix_data, fifo_data_in;
  logic       fifo_we, busy, line_done, frame_done, seq_err;
  logic [7:0] x, y, drop_cnt;

  logic       b_reset_n, b_frame_start, b_line_go, b_pix_valid, b_fifo_full;
  logic [5:0] b_pix_data, b_fifo_data_in;
  logic       b_fifo_we, b_busy, b_line_done, b_frame_done, b_seq_err;
  logic [7:0] b_x, b_y, b_drop_cnt;

  pixel_fifo_ctrl #(.DATA_W(6), .LINE_PIXELS(LP), .FRAME_LINES(FL)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .line_go(line_go),
    .pix_valid(pix_valid), .pix_data(pix_data), .fifo_full(fifo_full),
    .fifo_we(fifo_we), .fifo_data_in(fifo_data_in), .x(x), .y(y), .busy(busy),
    .line_done(line_done), .frame_done(frame_done), .drop_cnt(drop_cnt), .seq_err(seq_err)
  );

  pixel_fifo_ctrl dut_big (
    .clk(clk), .reset_n(b_reset_n), .frame_start(b_frame_start), .line_go(b_line_go),
    .pix_valid(b_pix_valid), .pix_data(b_pix_data), .fifo_full(b_fifo_full),
    .fifo_we(b_fifo_we), .fifo_data_in(b_fifo_data_in), .x(b_x), .y(b_y), .busy(b_busy),
    .line_done(b_line_done), .frame_done(b_frame_done), .drop_cnt(b_drop_cnt), .seq_err(b_seq_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 drawing, 2 holding; position = pixels consumed this frame.
  int m_phase, m_pos, m_drop;
  bit m_err;
  int n_wr, n_ld, n_fd;
  logic [5:0] wlog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input bit eld, input bit efd);
    chk("x", x, 32'(m_pos % LP));
    chk("y", y, 32'(m_pos / LP));
    chk("busy", busy, 32'(m_phase != 0));
    chk("line_done", line_done, 32'(eld));
    chk("frame_done", frame_done, 32'(efd));
    chk("drop_cnt", drop_cnt, 32'(m_drop));
    chk("seq_err", seq_err, 32'(m_err));
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic fs, input logic lg, input logic pv,
                      input logic [5:0] pd, input logic ff);
    bit ewe, eld, efd;
    frame_start = fs; line_go = lg; pix_valid = pv; pix_data = pd; fifo_full = ff;
    #1;
    ewe = (m_phase == 1) && pv && !ff && !fs;
    chk("fifo_we", fifo_we, 32'(ewe));
    if (ewe) chk("fifo_data_in", fifo_data_in, 32'(pd));
    if (fifo_we) begin
      n_wr++;
      wlog.push_back(fifo_data_in);
    end
    @(posedge clk); #1;
    eld = 0; efd = 0;
    if (fs) begin
      if (m_phase != 0) m_err = 1;
      m_phase = 1; m_pos = 0; m_drop = 0;
    end else if (m_phase == 0) begin
      if (pv) m_err = 1;
    end else if (m_phase == 1) begin
      if (pv) begin
        if (ff && m_drop < 255) m_drop++;
        m_pos++;
        if (m_pos % LP == 0) begin
          eld = 1;
          if (m_pos == LP * FL) begin
            efd = 1; m_phase = 0; m_pos = 0;
          end else begin
            m_phase = 2;
          end
        end
      end
    end else begin
      if (pv) m_err = 1;
      if (lg) m_phase = 1;
    end
    chk_outs(eld, efd);
    if (line_done) n_ld++;
    if (frame_done) n_fd++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 0; frame_start = 0; line_go = 0; pix_valid = 0; fifo_full = 0; pix_data = 0;
    @(posedge clk); #1;
    m_phase = 0; m_pos = 0; m_drop = 0; m_err = 0;
    chk_outs(0, 0);
    chk("rst_fifo_we", fifo_we, 0);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic run_line(input int first, input int full_mask);
    for (int p = 0; p < LP; p++)
      step(0, 0, 1, 6'(first + p), logic'((full_mask >> p) & 1));
  endtask

  int b_wr;

  initial begin
    reset_n = 0; frame_start = 0; line_go = 0; pix_valid = 0; pix_data = 0; fifo_full = 0;
    b_reset_n = 0; b_frame_start = 0; b_line_go = 0; b_pix_valid = 0; b_pix_data = 0; b_fifo_full = 0;
    m_phase = 0; m_pos = 0; m_drop = 0; m_err = 0;
    @(negedge clk);

    // Reset, idle, stray pixel
    do_reset();
    n_wr = 0;
    step(0, 0, 0, 6'h00, 0);
    step(0, 0, 1, 6'h20, 0);
    chk("idle_writes", n_wr, 0);
    chk("idle_seq_err", seq_err, 1);

    // Full frame without backpressure
    do_reset();
    n_wr = 0; n_ld = 0; n_fd = 0; wlog.delete();
    step(1, 0, 0, 6'h00, 0);
    for (int l = 0; l < FL; l++) begin
      run_line(l * LP + 1, 0);
      if (l < FL - 1) step(0, 1, 0, 6'h00, 0);
    end
    chk("frame_writes", n_wr, 12);
    for (int i = 0; i < wlog.size(); i++) chk("frame_order", wlog[i], 32'(i + 1));
    chk("frame_line_done_cnt", n_ld, 3);
    chk("frame_done_cnt", n_fd, 1);
    step(0, 0, 0, 6'h00, 0);
    chk("frame_busy_after", busy, 0);

    // Backpressure on pixels 2-3 of line 0
    n_wr = 0; wlog.delete();
    step(1, 0, 0, 6'h00, 0);
    run_line(1, 4'b0110);
    chk("bp_writes", n_wr, 2);
    chk("bp_first", wlog[0], 6'h01);
    chk("bp_second", wlog[1], 6'h04);
    chk("bp_drop_cnt", drop_cnt, 2);
    chk("bp_x_end", x, 0);
    chk("bp_line_wait", busy, 1);
    step(1, 0, 0, 6'h00, 0);
    chk("bp_drop_clear", drop_cnt, 0);

    // Line hold: strobes during LINE_WAIT
    do_reset();
    step(1, 0, 0, 6'h00, 0);
    run_line(1, 0);
    n_wr = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 6'(6'h30 + i), 0);
    chk("hold_writes", n_wr, 0);
    chk("hold_seq_err", seq_err, 1);
    chk("hold_x", x, 0);
    chk("hold_y", y, 1);
    step(0, 1, 0, 6'h00, 0);

    // Resync mid-line 1 at x=2
    do_reset();
    step(1, 0, 0, 6'h00, 0);
    run_line(1, 0);
    step(0, 1, 0, 6'h00, 0);
    step(0, 0, 1, 6'h05, 0);
    step(0, 0, 1, 6'h06, 0);
    chk("resync_pre_x", x, 2);
    n_wr = 0; n_fd = 0;
    step(1, 0, 1, 6'h07, 0);
    chk("resync_writes", n_wr, 0);
    chk("resync_x", x, 0);
    chk("resync_y", y, 0);
    chk("resync_busy", busy, 1);
    chk("resync_seq_err", seq_err, 1);
    chk("resync_no_fd", n_fd, 0);

    // Truncation: frame_start on the last pixel of the frame
    do_reset();
    step(1, 0, 0, 6'h00, 0);
    for (int l = 0; l < FL; l++) begin
      if (l < FL - 1) begin
        run_line(1, 0);
        step(0, 1, 0, 6'h00, 0);
      end else begin
        for (int p = 0; p < LP - 1; p++) step(0, 0, 1, 6'h11, 0);
      end
    end
    n_fd = 0;
    step(1, 0, 1, 6'h12, 0);
    chk("trunc_no_fd", n_fd, 0);
    chk("trunc_busy", busy, 1);

    // Reset mid-line at x=3, y=2
    do_reset();
    step(1, 0, 0, 6'h00, 0);
    run_line(1, 0);
    step(0, 1, 0, 6'h00, 0);
    run_line(5, 0);
    step(0, 1, 0, 6'h00, 0);
    for (int p = 0; p < 3; p++) step(0, 0, 1, 6'(9 + p), 0);
    chk("mid_x", x, 3);
    chk("mid_y", y, 2);
    do_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_x", x, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 2) == 0),
           logic'($urandom_range(0, 1)), 6'($urandom), logic'($urandom_range(0, 3) == 0));
    end

    // Default 256x240 geometry
    b_reset_n = 0;
    @(posedge clk); #1;
    chk("b_rst_x", b_x, 0);
    chk("b_rst_busy", b_busy, 0);
    b_reset_n = 1;
    @(negedge clk);
    b_frame_start = 1;
    @(posedge clk); #1;
    b_frame_start = 0;
    chk("b_start_busy", b_busy, 1);
    @(negedge clk);
    b_wr = 0;
    for (int l = 0; l < 240; l++) begin
      for (int p = 0; p < 256; p++) begin
        b_pix_valid = 1;
        b_pix_data = 6'($urandom);
        #1;
        if (b_fifo_we) b_wr++;
        @(posedge clk); #1;
        if (l == 0 && p == 254) chk("b_x_255", b_x, 255);
        @(negedge clk);
      end
      b_pix_valid = 0;
      chk("b_line_x", b_x, 0);
      chk("b_line_y", b_y, 32'((l + 1) % 240));
      chk("b_line_done", b_line_done, 1);
      chk("b_frame_done", b_frame_done, 32'(l == 239));
      if (l < 239) begin
        b_line_go = 1;
        @(posedge clk); #1;
        b_line_go = 0;
        @(negedge clk);
      end
    end
    chk("b_writes", b_wr, 61440);
    chk("b_busy_end", b_busy, 0);
    chk("b_seq_err", b_seq_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
